// File: rtl/player_input_ctrl_if.sv
// Player control bundle: raw push-buttons and game enable into the input
// controller, one-hot move code and shoot strobe out to the tank renderer.
interface player_input_ctrl_if;
    logic       enable_i;
    logic       btn_up_i;
    logic       btn_down_i;
    logic       btn_left_i;
    logic       btn_right_i;
    logic       btn_fire_i;
    logic [3:0] move_o;
    logic       shoot_o;
    logic       shoot_ready_o;

    modport slave (
        input  enable_i, btn_up_i, btn_down_i, btn_left_i, btn_right_i, btn_fire_i,
        output move_o, shoot_o, shoot_ready_o
    );

    modport master (
        output enable_i, btn_up_i, btn_down_i, btn_left_i, btn_right_i, btn_fire_i,
        input  move_o, shoot_o, shoot_ready_o
    );
endinterface

// File: rtl/player_input_ctrl.sv
// player_input_ctrl: one player's push-buttons -> synchronise, debounce,
// last-pressed-wins direction (one-hot move code) and a rate-limited shoot
// pulse. One instance per player on the pixel clock.
// Optional build macro PLAYER_INPUT_AUTOFIRE_EN: holding fire re-fires each
// time the cooldown expires; without it only a fresh fire press shoots.
module player_input_ctrl #(
    parameter int unsigned DEBOUNCE_CNT   = 250000,
    parameter int unsigned SHOOT_COOLDOWN = 12500000,
    parameter int unsigned CNT_W          = 24
) (
    input  logic                clk_i,
    input  logic                reset_i,
    player_input_ctrl_if.slave  bus
);
    // Button bit positions within the 5-bit vectors.
    localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_FIRE = 4;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] COOL_VAL = CNT_W'(SHOOT_COOLDOWN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

    logic [4:0]       raw;
    logic [4:0]       sync1_q, sync2_q;
    logic [4:0]       db_q, db_d, db_prev_q;
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];
    logic [4:0]       rise;
    dir_e             dir_q, dir_d;
    logic             cur_held;
    logic [3:0]       move_q, move_d;
    logic [CNT_W-1:0] cool_q, cool_d;
    logic             shoot_q, shoot_d;
    logic             ready_q, ready_d;
    logic             fire_req, trigger;

    // Highest-priority direction among a set of up/down/left/right flags.
    function automatic dir_e pick_dir(input logic [3:0] v);
        if (v[B_UP])         return DIR_UP;
        else if (v[B_DOWN])  return DIR_DOWN;
        else if (v[B_LEFT])  return DIR_LEFT;
        else if (v[B_RIGHT]) return DIR_RIGHT;
        else                 return DIR_NONE;
    endfunction

    function automatic logic [3:0] dir_to_move(input dir_e d);
        case (d)
            DIR_DOWN:  return 4'b0001;
            DIR_UP:    return 4'b0010;
            DIR_RIGHT: return 4'b0100;
            DIR_LEFT:  return 4'b1000;
            default:   return 4'b0000;
        endcase
    endfunction

    assign raw  = {bus.btn_fire_i, bus.btn_right_i, bus.btn_left_i,
                   bus.btn_down_i, bus.btn_up_i};
    assign rise = db_q & ~db_prev_q;

`ifdef PLAYER_INPUT_AUTOFIRE_EN
    assign fire_req = db_q[B_FIRE];
`else
    assign fire_req = rise[B_FIRE];
`endif

    assign trigger = fire_req & bus.enable_i & (cool_q == '0);

    // Debounce: accept a new level only after DEBOUNCE_CNT consecutive differing cycles.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Direction arbitration: newest press wins; on release fall back to a held button.
    always_comb begin
        dir_d = dir_q;
        case (dir_q)
            DIR_UP:    cur_held = db_q[B_UP];
            DIR_DOWN:  cur_held = db_q[B_DOWN];
            DIR_LEFT:  cur_held = db_q[B_LEFT];
            DIR_RIGHT: cur_held = db_q[B_RIGHT];
            default:   cur_held = 1'b0;
        endcase
        if (|rise[3:0]) begin
            dir_d = pick_dir(rise[3:0]);
        end else if (!cur_held) begin
            dir_d = pick_dir(db_q[3:0]);
        end
        move_d = bus.enable_i ? dir_to_move(dir_q) : 4'b0000;
    end

    // Shoot pulse and cooldown; ready drops in the same cycle the shot is taken.
    always_comb begin
        shoot_d = trigger;
        cool_d  = cool_q;
        if (trigger) begin
            cool_d = COOL_VAL;
        end else if (cool_q != '0) begin
            cool_d = cool_q - CNT_ONE;
        end
        ready_d = (cool_q == '0) & ~trigger;
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
            dir_q     <= DIR_NONE;
            move_q    <= 4'b0000;
            cool_q    <= '0;
            shoot_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
            dir_q     <= dir_d;
            move_q    <= move_d;
            cool_q    <= cool_d;
            shoot_q   <= shoot_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.move_o        = move_q;
    assign bus.shoot_o       = shoot_q;
    assign bus.shoot_ready_o = ready_q;
endmodule

// File: tb/tb_player_input_ctrl.sv
// Scoreboard bench for player_input_ctrl (DEBOUNCE_CNT=4, SHOOT_COOLDOWN=10).
// Stimulus pushes the cycle and value at which each output should change;
// a monitor pops and compares whenever an output changes or shoot_o pulses.
module tb_player_input_ctrl;
    localparam int D    = 4;
    localparam int COOL = 10;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;
    logic done    = 1'b0;
    int   cyc     = 0;

    player_input_ctrl_if pif ();

    player_input_ctrl #(
        .DEBOUNCE_CNT   (D),
        .SHOOT_COOLDOWN (COOL),
        .CNT_W          (8)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (pif)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [3:0] v;
    } exp_t;

    exp_t move_exp[$];
    exp_t rdy_exp[$];
    int   shoot_exp[$];

    function automatic void pm(input int c, input logic [3:0] v);
        exp_t e;
        e.c = c;
        e.v = v;
        move_exp.push_back(e);
    endfunction

    function automatic void pr(input int c, input logic v);
        exp_t e;
        e.c = c;
        e.v = {3'b000, v};
        rdy_exp.push_back(e);
    endfunction

    function automatic void ps(input int c);
        shoot_exp.push_back(c);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Monitor: all comparisons and the summary live here.
    int         total = 0;
    int         bad   = 0;
    logic [3:0] prev_move = 4'b0000;
    logic       prev_rdy  = 1'b1;

    initial begin
        exp_t e;
        int   sc;
        forever begin
            @(negedge clk_i or posedge reset_i);
            if (reset_i) begin
                #1;
                total += 3;
                if (pif.move_o !== 4'b0000) begin
                    bad++;
                    $display("FAIL reset_move: got %b required 0000", pif.move_o);
                end
                if (pif.shoot_o !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_shoot: got %b required 0", pif.shoot_o);
                end
                if (pif.shoot_ready_o !== 1'b1) begin
                    bad++;
                    $display("FAIL reset_ready: got %b required 1", pif.shoot_ready_o);
                end
                prev_move = pif.move_o;
                prev_rdy  = pif.shoot_ready_o;
            end else begin
                if (pif.move_o !== prev_move) begin
                    total++;
                    if (move_exp.size() == 0) begin
                        bad++;
                        $display("FAIL move_unexpected: got %b at cyc %0d, required no change from %b",
                                 pif.move_o, cyc, prev_move);
                    end else begin
                        e = move_exp.pop_front();
                        if (pif.move_o !== e.v || cyc != e.c) begin
                            bad++;
                            $display("FAIL move: got %b at cyc %0d, required %b at cyc %0d",
                                     pif.move_o, cyc, e.v, e.c);
                        end
                    end
                    prev_move = pif.move_o;
                end
                if (pif.shoot_ready_o !== prev_rdy) begin
                    total++;
                    if (rdy_exp.size() == 0) begin
                        bad++;
                        $display("FAIL ready_unexpected: got %b at cyc %0d, required no change",
                                 pif.shoot_ready_o, cyc);
                    end else begin
                        e = rdy_exp.pop_front();
                        if (pif.shoot_ready_o !== e.v[0] || cyc != e.c) begin
                            bad++;
                            $display("FAIL ready: got %b at cyc %0d, required %b at cyc %0d",
                                     pif.shoot_ready_o, cyc, e.v[0], e.c);
                        end
                    end
                    prev_rdy = pif.shoot_ready_o;
                end
                if (pif.shoot_o !== 1'b0) begin
                    total++;
                    if (shoot_exp.size() == 0) begin
                        bad++;
                        $display("FAIL shoot_unexpected: got %b at cyc %0d, required 0",
                                 pif.shoot_o, cyc);
                    end else begin
                        sc = shoot_exp.pop_front();
                        if (pif.shoot_o !== 1'b1 || cyc != sc) begin
                            bad++;
                            $display("FAIL shoot: got %b at cyc %0d, required 1 at cyc %0d",
                                     pif.shoot_o, cyc, sc);
                        end
                    end
                end
                if (done) begin
                    total += 3;
                    if (move_exp.size() != 0) begin
                        bad++;
                        $display("FAIL move_missing: got %0d pending, required 0", move_exp.size());
                    end
                    if (rdy_exp.size() != 0) begin
                        bad++;
                        $display("FAIL ready_missing: got %0d pending, required 0", rdy_exp.size());
                    end
                    if (shoot_exp.size() != 0) begin
                        bad++;
                        $display("FAIL shoot_missing: got %0d pending, required 0", shoot_exp.size());
                    end
                    $display("test done: total=%0d bad=%0d", total, bad);
                    $finish;
                end
            end
        end
    end

    // Directed stimulus; a raw change set at cycle c reaches move_o at c+8
    // and a fire press yields shoot_o at c+7.
    initial begin
        int c;
        pif.enable_i    = 1'b1;
        pif.btn_up_i    = 1'b0;
        pif.btn_down_i  = 1'b0;
        pif.btn_left_i  = 1'b0;
        pif.btn_right_i = 1'b0;
        pif.btn_fire_i  = 1'b0;
        tick(3);
        reset_i = 1'b0;
        tick(3);

        // Glitch of D-1 cycles is rejected, then a real press.
        pif.btn_up_i = 1'b1; tick(D - 1); pif.btn_up_i = 1'b0; tick(12);
        pif.btn_up_i = 1'b1; pm(cyc + 8, 4'b0010); tick(20);
        pif.btn_up_i = 1'b0; pm(cyc + 8, 4'b0000); tick(12);

        // Last pressed wins, release falls back to the held button.
        pif.btn_left_i  = 1'b1; pm(cyc + 8, 4'b1000); tick(12);
        pif.btn_right_i = 1'b1; pm(cyc + 8, 4'b0100); tick(12);
        pif.btn_right_i = 1'b0; pm(cyc + 8, 4'b1000); tick(12);
        pif.btn_left_i  = 1'b0; pm(cyc + 8, 4'b0000); tick(12);

        // Simultaneous press resolves by priority.
        pif.btn_up_i = 1'b1; pif.btn_right_i = 1'b1; pm(cyc + 8, 4'b0010); tick(12);
        pif.btn_up_i = 1'b0; pm(cyc + 8, 4'b0100); tick(12);
        pif.btn_right_i = 1'b0; pm(cyc + 8, 4'b0000); tick(12);

        // Cooldown: shot, dropped press during cooldown, then a held press.
        c = cyc;
        pif.btn_fire_i = 1'b1; ps(c + 7); pr(c + 7, 1'b0);
        tick(4); pif.btn_fire_i = 1'b0;
        tick(4); pif.btn_fire_i = 1'b1;
        tick(4); pif.btn_fire_i = 1'b0;
`ifdef PLAYER_INPUT_AUTOFIRE_EN
        ps(c + 18); ps(c + 29); ps(c + 40); ps(c + 51); pr(c + 62, 1'b1);
        tick(8); pif.btn_fire_i = 1'b1;
`else
        pr(c + 18, 1'b1);
        tick(8); pif.btn_fire_i = 1'b1; ps(c + 27); pr(c + 27, 1'b0); pr(c + 38, 1'b1);
`endif
        tick(30); pif.btn_fire_i = 1'b0;
        tick(20);

        // Enable low forces idle and ignores fire; raising it restores move.
        pif.btn_down_i = 1'b1; pm(cyc + 8, 4'b0001); tick(12);
        pif.enable_i = 1'b0; pm(cyc + 1, 4'b0000); tick(2);
        pif.btn_fire_i = 1'b1; tick(5); pif.btn_fire_i = 1'b0; tick(10);
        pif.enable_i = 1'b1; pm(cyc + 1, 4'b0001); tick(5);

        // Async reset mid-cooldown with down held, then re-debounce.
        c = cyc;
        pif.btn_fire_i = 1'b1; ps(c + 7); pr(c + 7, 1'b0);
        tick(5); pif.btn_fire_i = 1'b0;
        tick(5);
        #2 reset_i = 1'b1;
        tick(3);
        reset_i = 1'b0; pm(cyc + 8, 4'b0001); tick(12);
        pif.btn_down_i = 1'b0; pm(cyc + 8, 4'b0000); tick(12);
        done = 1'b1;
    end
endmodule

// File: doc/player_input_ctrl.md
Name: player_input_ctrl

Overview:
- Front end of the tank game's player control path. Converts one player's raw push-buttons into the one-hot move code and shoot strobe consumed by the player/tank renderer.
- Per button: two-flop synchroniser, then debounce.
- Last-pressed-wins direction arbitration drives a 4-bit one-hot move code.
- Fire generates a one-cycle shoot pulse, rate-limited by a cooldown counter.
- Instantiate once per player, on the pixel clock domain.

Parameters:
- DEBOUNCE_CNT, 250000: consecutive stable cycles before a raw level is accepted (10 ms at 25 MHz); must be >= 2.
- SHOOT_COOLDOWN, 12500000: cycles after a shot during which fire is ignored (0.5 s); must be >= 1.
- CNT_W, 24: width of the debounce and cooldown counters; must hold both parameter values.

Ports:
- clk_i, input, 1: system/pixel clock.
- reset_i, input, 1: asynchronous, active-high reset.
- enable_i, input, 1: game active; when low, move/shoot outputs are forced idle.
- btn_up_i, input, 1: raw button, asynchronous, active-high.
- btn_down_i, input, 1: raw button, asynchronous, active-high.
- btn_left_i, input, 1: raw button, asynchronous, active-high.
- btn_right_i, input, 1: raw button, asynchronous, active-high.
- btn_fire_i, input, 1: raw button, asynchronous, active-high.
- move_o, output, 4: one-hot move code: 0001 down, 0010 up, 0100 right, 1000 left, 0000 idle.
- shoot_o, output, 1: single-cycle shoot pulse.
- shoot_ready_o, output, 1: high when the cooldown has expired.

Behaviour:
- Reset (async assert, sync release): all sync flops, debounced states, counters, cur_dir and shoot_o are cleared. Outputs: move_o=0000, shoot_o=0, shoot_ready_o=1.
- Synchroniser: two flops per button; the second-stage value is called s_x.
- Debounce, per button:
  - Counter increments each cycle while s_x != db_x.
  - Counter clears whenever s_x == db_x.
  - When the counter equals DEBOUNCE_CNT-1 and s_x still differs: db_x <= s_x and the counter clears.
  - A glitch shorter than DEBOUNCE_CNT cycles never reaches db_x.
- Edge detect: rise_x = db_x & ~db_x_d (db_x_d is db_x delayed one cycle).
- Direction state register cur_dir has states NONE, UP, DOWN, LEFT, RIGHT. Transitions are evaluated each cycle in this order:
  1. Any rise_dir: cur_dir <= that direction. Simultaneous rises resolve by priority UP > DOWN > LEFT > RIGHT.
  2. Otherwise, if db of cur_dir is low: cur_dir <= highest-priority direction still held, or NONE if none held.
  3. Otherwise cur_dir holds.
- move_o:
  - Registered encoding of cur_dir; exactly one bit set, or 0000.
  - Forced to 0000 while enable_i=0. cur_dir keeps tracking underneath.
- Latency: a clean raw edge reaches move_o DEBOUNCE_CNT+4 clk_i edges after the first clock edge that samples the new level:
  - 2 edges for the synchroniser;
  - DEBOUNCE_CNT edges for debounce;
  - 1 edge for cur_dir;
  - 1 edge for the output register.
- Shoot:
  - Trigger: rise_fire & enable_i & (cooldown==0).
  - On trigger, shoot_o=1 for exactly the next cycle and cooldown <= SHOOT_COOLDOWN.
  - cooldown decrements by 1 per cycle to 0 and saturates there. It counts regardless of enable_i.
  - shoot_ready_o = (cooldown==0), registered.
  - A rise_fire while cooldown != 0 is dropped, not queued.
  - Holding fire does not re-fire.
- Counters never wrap: the debounce counter is bounded by clearing; cooldown saturates at 0.
- Reset asserted mid-press or mid-cooldown: everything is cleared immediately. After release, a still-held button must re-debounce, and it then produces a fresh rise.

Optional Feature:
- Macro: PLAYER_INPUT_AUTOFIRE_EN.
- Defined: while db_fire is held and enable_i=1, a shot also triggers whenever cooldown==0. Holding fire therefore fires every SHOOT_COOLDOWN+1 cycles.
- Undefined: only rise_fire triggers; holding fire yields exactly one shot.

Test Plan (DEBOUNCE_CNT=4, SHOOT_COOLDOWN=10, enable_i=1 unless stated):
- Glitch rejection: reset, pulse btn_up_i high for 3 cycles -> move_o stays 0000. Hold it 20 cycles -> move_o=0010 exactly 8 edges after the first sampled high.
- Last-pressed wins: hold left until move_o=1000, then press right -> move_o=0100. Release right -> 1000. Release left -> 0000.
- Simultaneous press: raise up and right in the same cycle -> move_o=0010. Then release up while right is held -> 0100.
- Cooldown: fire press -> one shoot_o pulse and shoot_ready_o=0 for 11 cycles. A second debounced press 5 cycles later -> no pulse. A press after shoot_ready_o=1 -> pulse.
- enable_i=0 while holding down -> move_o=0000 and fire ignored. Raise enable_i -> move_o=0001 on the next edge.
- Async reset mid-cooldown with down held -> all outputs at reset values immediately. After release, move_o=0001 after 8 edges. With PLAYER_INPUT_AUTOFIRE_EN, holding fire 40 cycles -> pulses spaced 11 cycles apart.
